conv_window_scheduler: RTL and testbench
========================================

# conv_window_scheduler

Sequencer that drives the convolution data mover across a full output feature map. On a run pulse it walks every valid KH×KW window position of an IH×IW input plane and launches one data-mover pass per position with the window's base address. It collects each accumulated result and writes it to the output-feature-map buffer. It sits between the layer-level control and the data mover, replacing the manual single-shot `i_run` trigger.

## Interface
- KH, 5, kernel height
- KW, 5, kernel width
- IH, 8, input plane height (≥ KH)
- IW, 8, input plane width (≥ KW)
- M_BW, 16, multiplier product width
- AC_BW, M_BW + $clog2(KW*KH), accumulated result width
- MEM_SIZE, 96, feature-map memory depth; AW = $clog2(MEM_SIZE)
- TIMEOUT, 64, max WAIT cycles per window before abort
- Derived: OH = IH-KH+1, OW = IW-KW+1, OA = $clog2(OH*OW)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_run  in  1  start pulse; sampled only in IDLE
- i_ifm_base  in  AW  input plane base address; latched on accepted i_run
- o_mv_run  out  1  one-cycle launch pulse to the data mover
- o_mv_addr  out  AW  window base address; valid while o_mv_run is high
- i_mv_valid  in  1  data mover result valid (o_final_valid)
- i_mv_result  in  AC_BW  data mover result (o_final_result)
- o_ofm_we  out  1  OFM buffer write enable, one cycle per window
- o_ofm_addr  out  OA  OFM write address = row*OW + col
- o_ofm_data  out  AC_BW  captured result
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse at end of map, normal or aborted
- o_err_timeout  out  1  sticky; cleared by the next accepted i_run

## Operation
- FSM states: IDLE, ISSUE, WAIT, WRITE, DONE.
- IDLE
  - If i_run=1: latch i_ifm_base, clear row/col, clear o_err_timeout, then go to ISSUE.
  - i_mv_valid is ignored.
- ISSUE
  - o_mv_run=1 for one cycle.
  - o_mv_addr = base + row*IW + col, computed modulo 2^AW. Wrap is silent.
  - Row offset is kept incrementally (row_base += IW); no multiplier.
  - Next state: WAIT.
- WAIT
  - The wait counter increments every cycle.
  - If i_mv_valid=1: capture i_mv_result into o_ofm_data, then go to WRITE.
  - Else if the counter reaches TIMEOUT-1: set o_err_timeout, then go to DONE.
  - Valid takes priority when it arrives in the same cycle the timeout is reached.
- WRITE
  - o_ofm_we=1 and o_ofm_addr = row*OW + col.
  - Advance col. When col wraps at OW-1, advance row.
  - After (OH-1, OW-1): go to DONE. Otherwise: go to ISSUE.
- DONE
  - o_done=1 for one cycle, then go to IDLE.
- i_run outside IDLE is ignored and never queued.
- i_mv_valid outside WAIT is ignored.
- Reset (asynchronous, any state)
  - FSM goes to IDLE.
  - Every output goes to 0, including o_ofm_data and o_err_timeout.
  - Counters are cleared.
  - Nothing resumes after reset is released.

## Timing
- i_run sampled high at edge 0 → ISSUE at cycle 1 (o_mv_run high).
- Mover returns valid L cycles after o_mv_run → WRITE at cycle 1+L+1.
- Per window: L+2 cycles. Total from i_run to o_done: OH*OW*(L+2)+1 cycles.
- All outputs are registered. No combinational path from any input to any output.
- o_busy falls in the cycle after o_done.

## Structure
- Shared package `conv_sched_pkg`:
  - FSM state enum.
  - Functions for OH/OW derivation.
  - AC_BW derivation, identical to the data mover's.
- One sub-module, `conv_pos_counter`:
  - Holds the row/col counter, incremental row_base and OFM address.
  - Inputs: clear, advance.
  - Outputs: last flag, o_mv_addr, o_ofm_addr.
- The FSM, wait counter and result capture stay in the top module.

## Test plan
All scenarios use default parameters (OH=OW=4, AW=7, 16 windows). The mock mover returns `result = address` with L=3.

- Nominal run, i_ifm_base=0, i_run at cycle 0:
  - o_mv_addr sequence is 0,1,2,3,8,9,10,11,16,…,27.
  - 16 writes with o_ofm_addr 0..15 carrying the matching data.
  - Last WRITE at cycle 80, o_done at cycle 81.
- Address wrap, i_ifm_base=120:
  - Row 0 addresses are 120..123.
  - Row 1 addresses are 0..3 (modulo 128).
  - 16 writes occur and no error is flagged.
- Timeout: the mover never asserts valid.
  - o_err_timeout rises after 64 WAIT cycles.
  - o_done pulses with no writes.
  - o_err_timeout stays high until the next i_run, which clears it.
- Valid on the final timeout cycle (mock L=64):
  - The result is captured and o_err_timeout stays 0.
- Reset mid-run: drop rst_n during WAIT of window 5.
  - All outputs read 0 immediately.
  - After release, a new i_run restarts at o_ofm_addr 0 with the new base.
- Extra i_run while busy, plus a stray i_mv_valid in IDLE and in ISSUE:
  - Both are ignored.
  - Exactly 16 writes occur and exactly one o_done pulse.

Source files
------------

// File: rtl/conv_sched_pkg.sv
// Shared types and elaboration-time helpers for the convolution window scheduler.
package conv_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    // Number of valid window positions along one axis.
    function automatic int out_dim(input int in_dim, input int k_dim);
        return in_dim - k_dim + 1;
    endfunction

    // Accumulator width, identical to the data mover's derivation.
    function automatic int acc_width(input int m_bw, input int kh, input int kw);
        return m_bw + $clog2(kw * kh);
    endfunction

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_window_scheduler_if.sv
// Launch/result handshake between the window scheduler (master) and the data mover (slave).
interface conv_window_scheduler_if #(
    parameter int AW    = 7,
    parameter int AC_BW = 21
);
    logic             o_mv_run;
    logic [AW-1:0]    o_mv_addr;
    logic             i_mv_valid;
    logic [AC_BW-1:0] i_mv_result;

    modport master (
        output o_mv_run,
        output o_mv_addr,
        input  i_mv_valid,
        input  i_mv_result
    );

    modport slave (
        input  o_mv_run,
        input  o_mv_addr,
        output i_mv_valid,
        output i_mv_result
    );
endinterface

// File: rtl/conv_pos_counter.sv
// Row/column walker over the output map: keeps the window base address incrementally and the OFM index.
module conv_pos_counter
    import conv_sched_pkg::*;
#(
    parameter int IW = 8,
    parameter int OH = 4,
    parameter int OW = 4,
    parameter int AW = 7,
    parameter int OA = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clear,
    input  logic [AW-1:0] i_base,
    input  logic          i_advance,
    output logic          o_last,
    output logic [AW-1:0] o_mv_addr,
    output logic [OA-1:0] o_ofm_addr
);

    localparam int RW = width_of(OH);
    localparam int CW = width_of(OW);

    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic [AW-1:0] mv_addr_q, mv_addr_d;
    logic [OA-1:0] ofm_addr_q, ofm_addr_d;
    logic          col_last;
    logic          row_last;

    assign col_last = (col_q == CW'(OW - 1));
    assign row_last = (row_q == RW'(OH - 1));

    // Address arithmetic wraps modulo 2^AW by construction.
    always_comb begin
        row_d      = row_q;
        col_d      = col_q;
        row_base_d = row_base_q;
        mv_addr_d  = mv_addr_q;
        ofm_addr_d = ofm_addr_q;
        if (i_clear) begin
            row_d      = '0;
            col_d      = '0;
            row_base_d = i_base;
            mv_addr_d  = i_base;
            ofm_addr_d = '0;
        end else if (i_advance) begin
            ofm_addr_d = ofm_addr_q + OA'(1);
            if (col_last) begin
                col_d      = '0;
                row_d      = row_q + RW'(1);
                row_base_d = row_base_q + AW'(IW);
                mv_addr_d  = row_base_q + AW'(IW);
            end else begin
                col_d     = col_q + CW'(1);
                mv_addr_d = mv_addr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q      <= '0;
            col_q      <= '0;
            row_base_q <= '0;
            mv_addr_q  <= '0;
            ofm_addr_q <= '0;
        end else begin
            row_q      <= row_d;
            col_q      <= col_d;
            row_base_q <= row_base_d;
            mv_addr_q  <= mv_addr_d;
            ofm_addr_q <= ofm_addr_d;
        end
    end

    assign o_last     = row_last && col_last;
    assign o_mv_addr  = mv_addr_q;
    assign o_ofm_addr = ofm_addr_q;

endmodule

// File: rtl/conv_window_scheduler.sv
// Walks every KHxKW window of an IHxIW plane, launches one data-mover pass per window
// and writes each returned result to the OFM buffer.
module conv_window_scheduler
    import conv_sched_pkg::*;
#(
    parameter int KH       = 5,
    parameter int KW       = 5,
    parameter int IH       = 8,
    parameter int IW       = 8,
    parameter int M_BW     = 16,
    parameter int AC_BW    = acc_width(M_BW, KH, KW),
    parameter int MEM_SIZE = 96,
    parameter int TIMEOUT  = 64,
    parameter int AW       = $clog2(MEM_SIZE),
    parameter int OH       = out_dim(IH, KH),
    parameter int OW       = out_dim(IW, KW),
    parameter int OA       = width_of(OH * OW)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_run,
    input  logic [AW-1:0]           i_ifm_base,
    conv_window_scheduler_if.master mv,
    output logic                    o_ofm_we,
    output logic [OA-1:0]           o_ofm_addr,
    output logic [AC_BW-1:0]        o_ofm_data,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err_timeout
);

    localparam int WCW = width_of(TIMEOUT);

    state_t             state_q, state_d;
    logic [WCW-1:0]     wait_q, wait_d;
    logic [AC_BW-1:0]   data_q, data_d;
    logic               err_q, err_d;
    logic               mv_run_q, mv_run_d;
    logic               we_q, we_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pos_clear;
    logic               pos_advance;
    logic               pos_last;
    logic [AW-1:0]      pos_mv_addr;
    logic [OA-1:0]      pos_ofm_addr;

    conv_pos_counter #(
        .IW (IW),
        .OH (OH),
        .OW (OW),
        .AW (AW),
        .OA (OA)
    ) u_pos (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (pos_clear),
        .i_base     (i_ifm_base),
        .i_advance  (pos_advance),
        .o_last     (pos_last),
        .o_mv_addr  (pos_mv_addr),
        .o_ofm_addr (pos_ofm_addr)
    );

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        data_d      = data_q;
        err_d       = err_q;
        pos_clear   = 1'b0;
        pos_advance = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_run) begin
                    pos_clear = 1'b1;
                    err_d     = 1'b0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            // A result arriving on the last allowed cycle still wins over the abort.
            S_WAIT: begin
                wait_d = wait_q + WCW'(1);
                if (mv.i_mv_valid) begin
                    data_d  = mv.i_mv_result;
                    state_d = S_WRITE;
                end else if (wait_q == WCW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WRITE: begin
                pos_advance = 1'b1;
                state_d     = pos_last ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes are registered from the next state so outputs never see inputs combinationally.
        mv_run_d = (state_d == S_ISSUE);
        we_d     = (state_d == S_WRITE);
        done_d   = (state_d == S_DONE);
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wait_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            mv_run_q <= 1'b0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            data_q   <= data_d;
            err_q    <= err_d;
            mv_run_q <= mv_run_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign mv.o_mv_run   = mv_run_q;
    assign mv.o_mv_addr  = pos_mv_addr;
    assign o_ofm_we      = we_q;
    assign o_ofm_addr    = pos_ofm_addr;
    assign o_ofm_data    = data_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_err_timeout = err_q;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Randomized bench for conv_window_scheduler with a mock data mover returning result = address.
module tb_conv_window_scheduler;

    localparam int AW    = 7;
    localparam int AC_BW = 21;
    localparam int OA    = 4;
    localparam int OH    = 4;
    localparam int OW    = 4;
    localparam int IW    = 8;
    localparam int NWIN  = OH * OW;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_run;
    logic [AW-1:0]    i_ifm_base;
    logic             o_ofm_we;
    logic [OA-1:0]    o_ofm_addr;
    logic [AC_BW-1:0] o_ofm_data;
    logic             o_busy;
    logic             o_done;
    logic             o_err_timeout;

    conv_window_scheduler_if #(.AW(AW), .AC_BW(AC_BW)) mv ();

    conv_window_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_run         (i_run),
        .i_ifm_base    (i_ifm_base),
        .mv            (mv),
        .o_ofm_we      (o_ofm_we),
        .o_ofm_addr    (o_ofm_addr),
        .o_ofm_data    (o_ofm_data),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err_timeout (o_err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_iss = 0;
    int          n_wr = 0;
    int          n_done = 0;
    int          iss0 = 0;
    int          wr0 = 0;
    int          done0 = 0;
    int          done_cyc = 0;
    int          last_wr_cyc = 0;
    int          mock_L = 3;
    bit          mock_never = 1'b0;
    bit          stray_idle = 1'b0;
    bit          stray_issue = 1'b0;
    logic [AW-1:0] cur_base = '0;
    logic [63:0] iss_log [NWIN];

    // Mock mover: result equals launch address, valid for one cycle L cycles after o_mv_run.
    int          due = -1;
    logic [AW-1:0] pend = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            due = -1;
        end else if (mv.o_mv_run && !mock_never) begin
            due  = cyc + mock_L;
            pend = mv.o_mv_addr;
        end
        mv.i_mv_valid  = (rst_n && cyc == due) || stray_idle || (stray_issue && mv.o_mv_run);
        mv.i_mv_result = (cyc == due) ? AC_BW'(pend) : AC_BW'(21'h1BEEF);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Window idx of a map starting at base: row-major, address wraps modulo 2^AW.
    function automatic logic [63:0] model_addr(input int base, input int idx);
        if (idx < 0 || idx >= NWIN) return '1;
        return 64'((base + (idx / OW) * IW + (idx % OW)) % (1 << AW));
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_run(input logic [AW-1:0] base, input int L, input bit never,
                             input bit extra, output int r);
        mock_L     = L;
        mock_never = never;
        cur_base   = base;
        iss0       = n_iss;
        wr0        = n_wr;
        done0      = n_done;
        if (extra) begin
            stray_idle = 1'b1;
            step();
            stray_idle = 1'b0;
        end
        i_run      = 1'b1;
        i_ifm_base = base;
        r          = cyc;
        step();
        i_run      = 1'b0;
        i_ifm_base = AW'($urandom);
        stray_issue = extra;
        chk("busy_at_issue", 64'(o_busy), 64'd1);
        chk("err_cleared_on_run", 64'(o_err_timeout), 64'd0);
    endtask

    task automatic finish_run(input int r, input int L, input bit never, input bit extra);
        int budget;
        budget = never ? 200 : NWIN * (L + 2) + 50;
        for (int k = 0; k < budget && n_done == done0; k++) begin
            i_run = extra && (cyc - r == 10);
            if (i_run) i_ifm_base = 7'd77;
            step();
        end
        i_run       = 1'b0;
        stray_issue = 1'b0;
        chk("done_pulse", 64'(n_done - done0), 64'd1);
        if (never) begin
            chk("timeout_done_cycle", 64'(done_cyc - r), 64'd66);
            chk("timeout_writes", 64'(n_wr - wr0), 64'd0);
            chk("timeout_issues", 64'(n_iss - iss0), 64'd1);
            chk("timeout_err", 64'(o_err_timeout), 64'd1);
        end else begin
            chk("done_cycle", 64'(done_cyc - r), 64'(NWIN * (L + 2) + 1));
            chk("write_count", 64'(n_wr - wr0), 64'(NWIN));
            chk("issue_count", 64'(n_iss - iss0), 64'(NWIN));
            chk("no_err", 64'(o_err_timeout), 64'd0);
        end
        step();
        chk("busy_after_done", 64'(o_busy), 64'd0);
        repeat (15) step();
        chk("single_done", 64'(n_done - done0), 64'd1);
        chk("no_requeue", 64'(n_iss - iss0), never ? 64'd1 : 64'(NWIN));
    endtask

    task automatic run_map(input logic [AW-1:0] base, input int L, input bit never, input bit extra);
        int r;
        start_run(base, L, never, extra, r);
        finish_run(r, L, never, extra);
    endtask

    initial begin
        int r;
        int wr_snap;
        int done_snap;
        rst_n      = 1'b0;
        i_run      = 1'b0;
        i_ifm_base = '0;

        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (mv.o_mv_run) begin
                        chk("mv_addr", 64'(mv.o_mv_addr), model_addr(int'(cur_base), n_iss - iss0));
                        if (n_iss - iss0 < NWIN) iss_log[n_iss - iss0] = 64'(mv.o_mv_addr);
                        n_iss++;
                    end
                    if (o_ofm_we) begin
                        chk("ofm_addr", 64'(o_ofm_addr),
                            (n_wr - wr0 < NWIN) ? 64'(n_wr - wr0) : '1);
                        chk("ofm_data", 64'(o_ofm_data), model_addr(int'(cur_base), n_wr - wr0));
                        last_wr_cyc = cyc;
                        n_wr++;
                    end
                    if (o_done) begin
                        done_cyc = cyc;
                        n_done++;
                    end
                end
            end
        join_none

        repeat (3) step();
        chk("reset_state", 64'({mv.o_mv_run, mv.o_mv_addr, o_ofm_we, o_ofm_addr, o_ofm_data,
                                o_busy, o_done, o_err_timeout}), 64'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // Nominal map from base 0.
        start_run(7'd0, 3, 1'b0, 1'b0, r);
        finish_run(r, 3, 1'b0, 1'b0);
        chk("nominal_addr4", iss_log[4], 64'd8);
        chk("nominal_addr15", iss_log[15], 64'd27);
        chk("nominal_last_write", 64'(last_wr_cyc - r), 64'd80);
        chk("nominal_done81", 64'(done_cyc - r), 64'd81);

        // Base near the top of memory: row 1 wraps to 0.
        run_map(7'd120, 3, 1'b0, 1'b0);
        chk("wrap_addr3", iss_log[3], 64'd123);
        chk("wrap_addr4", iss_log[4], 64'd0);
        chk("wrap_addr7", iss_log[7], 64'd3);

        // Mover never answers.
        run_map(AW'($urandom), 3, 1'b1, 1'b0);
        repeat (5) step();
        chk("err_sticky", 64'(o_err_timeout), 64'd1);

        // Valid on the final allowed WAIT cycle.
        run_map(AW'($urandom), 64, 1'b0, 1'b0);

        // Asynchronous reset during WAIT of window 5.
        start_run(7'd5, 3, 1'b0, 1'b0, r);
        for (int k = 0; k < 200 && (n_iss - iss0) < 5; k++) step();
        chk("reached_window5", 64'(n_iss - iss0), 64'd5);
        step();
        wr_snap   = n_wr;
        done_snap = n_done;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_outs", 64'({mv.o_mv_run, mv.o_mv_addr, o_ofm_we, o_ofm_addr, o_ofm_data,
                                      o_busy, o_done, o_err_timeout}), 64'd0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (10) step();
        chk("no_resume_busy", 64'(o_busy), 64'd0);
        chk("no_resume_writes", 64'(n_wr - wr_snap), 64'd0);
        chk("no_resume_done", 64'(n_done - done_snap), 64'd0);
        run_map(7'd33, 3, 1'b0, 1'b0);

        // Extra i_run while busy and stray valids in IDLE and ISSUE.
        run_map(AW'($urandom), 3, 1'b0, 1'b1);

        // Random bases and latencies.
        for (int i = 0; i < 4; i++) begin
            run_map(AW'($urandom), int'($urandom_range(1, 8)), 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule
